// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte sources using a round-robin
// arbiter. A requester can lock the transmitter for a frame. Each byte is followed through send, busy and idle.
module uart_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_lock,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_send,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              timeout,
   output logic [1:0]        dbg_state
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_IDLE = 2'd3
   } state_t;

   state_t          r_state, w_next;
   logic [PW-1:0]   r_ptr, r_gidx, r_owner, w_win, w_gidx_inc;
   logic            r_lock;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_tx_data;
   logic            r_timeout;
   logic [NREQ-1:0] w_elig, w_cand;
   logic [PW:0]     w_sum;
   logic            w_found, w_accept, w_expire, w_done, w_drop;

   // Handshake: byte i is consumed in the cycle req_ready[i]=1 while req_valid[i]=1; the
   // source must hold req_valid/req_data until then and may drop or replace them afterwards.
   assign w_elig     = r_lock ? (NREQ'(1) << r_owner) : '1;
   assign w_cand     = req_valid & w_elig;
   assign w_gidx_inc = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
         if (!w_found && w_cand[w_sum[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[PW-1:0];
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) && !rst && tx_ready && w_found;
   assign w_drop   = (r_state == S_IDLE) && r_lock && !req_valid[r_owner] && !req_lock[r_owner];
   assign w_expire = (r_state == S_WAIT_BUSY) && tx_ready && (r_cnt == CW'(ACK_TIMEOUT - 1));
   assign w_done   = (r_state == S_WAIT_IDLE) && tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_accept) w_next = S_SEND;
         S_SEND:      w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!tx_ready)     w_next = S_WAIT_IDLE;
            else if (w_expire) w_next = S_IDLE;
         end
         S_WAIT_IDLE: if (tx_ready) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      grant     = '0;
      if (w_accept) req_ready[w_win] = 1'b1;
      if (r_state != S_IDLE) grant[r_gidx] = 1'b1;
      tx_send   = (r_state == S_SEND);
      busy      = (r_state != S_IDLE);
   end

   assign tx_data   = r_tx_data;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

   // A lost acknowledge releases the lock and moves the pointer on, so one stuck source cannot hold the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr     <= '0;
         r_lock    <= 1'b0;
         r_owner   <= '0;
         r_gidx    <= '0;
         r_cnt     <= '0;
         r_tx_data <= 8'h00;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (r_state == S_WAIT_BUSY) r_cnt <= r_cnt + 1'b1;
         else                        r_cnt <= '0;
         if (w_accept) begin
            r_gidx    <= w_win;
            r_tx_data <= req_data[{w_win, 3'b000} +: 8];
         end
         if (w_expire) begin
            r_lock <= 1'b0;
            r_ptr  <= w_gidx_inc;
         end else if (w_done) begin
            if (req_lock[r_gidx]) begin
               r_lock  <= 1'b1;
               r_owner <= r_gidx;
               r_ptr   <= r_gidx;
            end else begin
               r_lock <= 1'b0;
               r_ptr  <= w_gidx_inc;
            end
         end else if (w_drop) begin
            r_lock <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences (lock, timeout, reset, busy line)
// and a randomized run scored against a transaction-level arbitration model.
module tb_uart_tx_arbiter;
   localparam int NREQ        = 4;
   localparam int ACK_TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_lock, req_ready, grant;
   logic [8*NREQ-1:0] req_data;
   logic              tx_send, tx_ready, busy, timeout;
   logic [7:0]        tx_data;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] valid;
      logic       txr;
      logic [3:0] exp_ready;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vt[7];

   logic [7:0]      exp_q[$];
   logic [7:0]      cur_byte;
   logic [NREQ-1:0] last_ready;
   logic [NREQ-1:0] exp_r;
   logic            last_send;
   int m_ptr, m_owner, m_g, xc, w, tx_ph, tx_dly, tx_bz;
   bit m_busy, fell;

   uart_tx_arbiter #(.NREQ(NREQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
      .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_cycle();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      tx_ready  = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string nm);
      check(nm, 32'({req_ready, tx_send, tx_data, grant, busy, timeout, dbg_state}), 32'd0);
   endtask

   // Full transfer with a well-behaved transmitter; expects requester idx to win.
   task automatic xfer(input int idx, input string nm);
      int n;
      logic [7:0] d;
      n = 0;
      mid_cycle();
      while (req_ready == '0 && n < 20) begin
         next_cycle();
         mid_cycle();
         n++;
      end
      check({nm, "_ready"}, 32'(req_ready), 32'(1 << idx));
      d = req_data[8*idx +: 8];
      next_cycle();
      mid_cycle();
      check({nm, "_send"}, 32'({tx_send, tx_data}), 32'({1'b1, d}));
      check({nm, "_grant"}, 32'(grant), 32'(1 << idx));
      next_cycle();
      tx_ready = 1'b0;
      next_cycle();
      next_cycle();
      tx_ready = 1'b1;
      mid_cycle();
      check({nm, "_hold"}, 32'(grant), 32'(1 << idx));
      next_cycle();
   endtask

   initial begin
      vt[0] = '{4'b0100, 1'b1, 4'b0100, 8'hA5};
      vt[1] = '{4'b0000, 1'b1, 4'b0000, 8'h00};
      vt[2] = '{4'b1010, 1'b1, 4'b0010, 8'h61};
      vt[3] = '{4'b1111, 1'b0, 4'b0000, 8'h00};
      vt[4] = '{4'b1000, 1'b1, 4'b1000, 8'hD3};
      vt[5] = '{4'b1111, 1'b1, 4'b0001, 8'h1F};
      vt[6] = '{4'b0110, 1'b1, 4'b0010, 8'h61};

      req_data  = 32'hD3A5_611F;
      rst       = 1'b1;
      req_valid = '1;
      req_lock  = '0;
      tx_ready  = 1'b1;
      next_cycle();
      mid_cycle();
      check_all_zero("reset_outputs");

      // Table vectors, each from a fresh reset so the pointer starts at 0.
      for (int v = 0; v < 7; v++) begin
         reset_dut();
         req_valid = vt[v].valid;
         tx_ready  = vt[v].txr;
         mid_cycle();
         check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vt[v].exp_ready));
         check($sformatf("vec%0d_idle", v), 32'({busy, grant}), 32'd0);
         next_cycle();
         req_valid = '0;
         mid_cycle();
         if (vt[v].exp_ready != 4'b0000) begin
            check($sformatf("vec%0d_send", v), 32'({tx_send, tx_data}), 32'({1'b1, vt[v].exp_data}));
            check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].exp_ready));
         end else begin
            check($sformatf("vec%0d_nosend", v), 32'({tx_send, busy, grant}), 32'd0);
         end
      end

      // Round robin with every source valid from reset.
      reset_dut();
      req_valid = '1;
      for (int i = 0; i < 5; i++) xfer(i % NREQ, $sformatf("rr%0d", i));

      // Lock: owner 1 keeps the line even while it has nothing to send.
      reset_dut();
      req_valid = 4'b0010;
      req_lock  = 4'b0010;
      xfer(1, "lk1");
      req_valid = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         mid_cycle();
         check("lk_hold", 32'(req_ready), 32'd0);
         next_cycle();
      end
      req_valid = 4'b0111;
      xfer(1, "lk2");
      req_lock = 4'b0000;
      xfer(1, "lk3");
      xfer(2, "lk4");

      // Lock dropped while the owner is idle reopens arbitration one cycle later.
      reset_dut();
      req_valid = 4'b0001;
      req_lock  = 4'b0001;
      xfer(0, "dr1");
      req_valid = 4'b1010;
      mid_cycle();
      check("dr_wait", 32'(req_ready), 32'd0);
      next_cycle();
      req_lock = 4'b0000;
      mid_cycle();
      check("dr_edge", 32'(req_ready), 32'd0);
      next_cycle();
      mid_cycle();
      check("dr_open", 32'(req_ready), 32'b0010);

      // Timeout: transmitter never goes busy.
      reset_dut();
      req_valid = 4'b0100;
      mid_cycle();
      check("to_ready", 32'(req_ready), 32'b0100);
      next_cycle();
      req_valid = 4'b1101;
      mid_cycle();
      check("to_send", 32'(tx_send), 32'd1);
      for (int j = 1; j <= ACK_TIMEOUT; j++) begin
         next_cycle();
         mid_cycle();
         check($sformatf("to_wait%0d", j), 32'({timeout, busy}), 32'b01);
      end
      next_cycle();
      mid_cycle();
      check("to_pulse", 32'({timeout, busy}), 32'b10);
      check("to_ptr_adv", 32'(req_ready), 32'b1000);
      next_cycle();
      mid_cycle();
      check("to_one_cycle", 32'(timeout), 32'd0);

      // Transmitter busy in IDLE holds off acceptance.
      reset_dut();
      tx_ready  = 1'b0;
      req_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         mid_cycle();
         check("txb_hold", 32'(req_ready), 32'd0);
         next_cycle();
      end
      tx_ready = 1'b1;
      mid_cycle();
      check("txb_accept", 32'(req_ready), 32'b0010);

      // Reset in WAIT_IDLE abandons the byte and rewinds the pointer.
      reset_dut();
      req_valid = 4'b0001;
      xfer(0, "rs1");
      req_valid = 4'b0101;
      mid_cycle();
      check("rs_win", 32'(req_ready), 32'b0100);
      next_cycle();
      next_cycle();
      tx_ready = 1'b0;
      next_cycle();
      mid_cycle();
      check("rs_wait_idle", 32'({busy, grant}), 32'b10100);
      next_cycle();
      rst = 1'b1;
      mid_cycle();
      check_all_zero("rs_during0");
      next_cycle();
      mid_cycle();
      check_all_zero("rs_during1");
      next_cycle();
      rst      = 1'b0;
      tx_ready = 1'b1;
      mid_cycle();
      check("rs_first", 32'(req_ready), 32'b0001);

      // Randomized run against the arbitration model.
      reset_dut();
      m_ptr = 0; m_owner = -1; m_g = 0; xc = 0; m_busy = 0; fell = 0;
      tx_ph = 0; tx_dly = 0; tx_bz = 0;
      last_ready = '0; last_send = 1'b0; cur_byte = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && last_ready[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[i]         = 1'b1;
                  req_data[8*i +: 8]   = 8'($urandom);
                  req_lock[i]          = ($urandom_range(0, 2) == 0);
               end else if ($urandom_range(0, 3) != 0) begin
                  req_lock[i] = 1'b0;
               end
            end
         end
         if (last_send) begin
            tx_dly = $urandom_range(0, 4);
            tx_ph  = 1;
         end
         if (tx_ph == 1) begin
            if (tx_dly == 0) begin
               tx_ready = 1'b0;
               tx_bz    = $urandom_range(1, 5);
               tx_ph    = 2;
            end else begin
               tx_dly--;
            end
         end else if (tx_ph == 2) begin
            tx_bz--;
            if (tx_bz == 0) begin
               tx_ready = 1'b1;
               tx_ph    = 0;
            end
         end

         mid_cycle();
         if (!m_busy) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) begin
               int id;
               id = (m_ptr + j) % NREQ;
               if (w < 0 && req_valid[id] && (m_owner < 0 || m_owner == id)) w = id;
            end
            exp_r = (tx_ready && w >= 0) ? NREQ'(1 << w) : '0;
            check("rnd_ready", 32'(req_ready), 32'(exp_r));
            check("rnd_idle", 32'({tx_send, busy, grant, timeout}), 32'd0);
            if (exp_r != '0) begin
               exp_q.push_back(req_data[8*w +: 8]);
               m_g = w; m_busy = 1; xc = 0; fell = 0;
            end else if (m_owner >= 0 && !req_valid[m_owner] && !req_lock[m_owner]) begin
               m_owner = -1;
            end
         end else begin
            xc++;
            if (xc == 1) begin
               check("rnd_send", 32'(tx_send), 32'd1);
               if (exp_q.size() > 0) cur_byte = exp_q.pop_front();
            end else begin
               check("rnd_nosend", 32'(tx_send), 32'd0);
            end
            check("rnd_data", 32'(tx_data), 32'(cur_byte));
            check("rnd_grant", 32'(grant), 32'(1 << m_g));
            check("rnd_busy", 32'({busy, req_ready, timeout}), 32'({1'b1, 4'b0000, 1'b0}));
            if (xc >= 2 && !tx_ready) begin
               fell = 1;
            end else if (fell && tx_ready) begin
               if (req_lock[m_g]) begin
                  m_owner = m_g;
                  m_ptr   = m_g;
               end else begin
                  m_owner = -1;
                  m_ptr   = (m_g + 1) % NREQ;
               end
               m_busy = 0;
            end
         end
         last_ready = req_ready;
         last_send  = tx_send;
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
